register_file: RTL and testbench
================================

# register_file

Architectural register file with rename tags for the out-of-order RISC-V core. It holds the 32 committed values and, per register, the ROB ID of the youngest in-flight writer. It answers the dispatcher's operand lookups as either a value or a ROB tag, and absorbs the commit stream the reorder buffer emits. It sits between dispatcher (rename/lookup side) and reorder buffer (commit side), and is flushed on misbranch.

## Interface
Parameters:
- REG_NUM, 32, architectural registers; x0 hardwired zero
- ROB IDs are 5-bit: 0 means "no tag", 1..16 are valid entries

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low holds all state
- rs1_from_dispatcher  in  5  source register 1 index
- rs2_from_dispatcher  in  5  source register 2 index
- Q1_to_dispatcher  out  5  ROB tag of rs1 (0 = value valid)
- V1_to_dispatcher  out  32  value of rs1 (valid when Q1 = 0)
- Q2_to_dispatcher  out  5  ROB tag of rs2
- V2_to_dispatcher  out  32  value of rs2
- rename_signal_from_dispatcher  in  1  allocate tag for rd this cycle
- rd_from_dispatcher  in  5  destination register
- rob_id_from_dispatcher  in  5  ROB ID allocated to the instruction
- commit_flag_from_rob  in  1  commit write valid
- rd_from_rob  in  5  committed destination
- Q_from_rob  in  5  ROB ID of committing entry
- V_from_rob  in  32  committed value
- misbranch_flag_from_rob  in  1  flush all tags

## Operation
- State: value[0..31] (32b) and tag[0..31] (5b); reset clears both to 0.
- Lookup (combinational), per source rsN:
  - rsN = 0 -> Q = 0, V = 0.
  - Same-cycle commit forwarding: if commit_flag && rd_from_rob = rsN && tag[rsN] = Q_from_rob -> Q = 0, V = V_from_rob.
  - Otherwise -> Q = tag[rsN], V = value[rsN].
  - A rename in the same cycle never affects the lookup: an instruction reads its sources before renaming its own rd (add x1,x1,x2 sees the old x1 mapping).
- Commit (clocked): if commit_flag && rd_from_rob ≠ 0 -> value[rd] <= V_from_rob. tag[rd] <= 0 only if tag[rd] = Q_from_rob; a younger writer's tag is preserved.
- Rename (clocked): if rename_signal && rd ≠ 0 && !misbranch -> tag[rd] <= rob_id_from_dispatcher.
- Commit and rename to the same rd in the same cycle: the value is written and the tag becomes the new rob_id; rename wins over tag clear.
- Misbranch (clocked): all tags <= 0; values are untouched. A commit in the same cycle still writes its value. A rename in the same cycle is dropped.
- Writes to x0 are ignored for both value and tag.
- rdy low: no state changes. Lookup outputs remain combinational from the held state.

## Timing
- Lookup latency 0 cycles (combinational, including commit forwarding).
- Commit and rename become visible in state at the next rising edge.
- Flush takes effect at the next edge. From that cycle on, every lookup returns Q = 0.
- Reset outputs: with state cleared, every Q = 0 and V = 0 regardless of rs inputs.
- No handshake: the dispatcher guarantees that rename is only asserted when the ROB has accepted the allocation.

## Structure
- Shared constants belong in the common header: ROB_ID_TYPE [4:0], REG_POS_TYPE [4:0], DATA_TYPE [31:0], ZERO_ROB, ZERO_REG, ZERO_WORD, TRUE/FALSE.
- Single flat module; no sub-module is warranted. The two read ports are identical logic, which may be written as a function.

## Test plan
- Reset, then look up rs1 = 5, rs2 = 0 -> Q1 = 0, V1 = 0, Q2 = 0, V2 = 0.
- Rename x3 -> ROB 4; next cycle look up x3 -> Q = 4. Then commit rd = 3, Q = 4, V = 0xDEADBEEF -> same-cycle lookup gives Q = 0, V = 0xDEADBEEF; next cycle tag[3] = 0.
- Rename x3 -> ROB 4, then x3 -> ROB 7, then commit (3, 4, 0x11) -> value[3] = 0x11, and lookup of x3 still gives Q = 7 (no forwarding, since the tag mismatches).
- Same cycle: commit (8, 2, 0x55) and rename x8 -> ROB 9 -> next cycle value[8] = 0x55, tag[8] = 9.
- Tags on x1, x2, x31, then misbranch with a simultaneous commit (2, tag, 0x77) and rename x5 -> next cycle all Q = 0, value[2] = 0x77, x5 untagged.
- Rename x0 and commit to x0 with V = 0x1234 -> lookup of x0 gives Q = 0, V = 0. With rdy low, a rename of x6 is ignored.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and constants for the architectural register file.
// Lookup results and the operand lookup helper also live here.
package register_file_pkg;

  localparam int REG_NUM = 32;

  typedef logic [4:0]  ROB_ID_TYPE;
  typedef logic [4:0]  REG_POS_TYPE;
  typedef logic [31:0] DATA_TYPE;

  localparam ROB_ID_TYPE  ZERO_ROB  = 5'd0;
  localparam REG_POS_TYPE ZERO_REG  = 5'd0;
  localparam DATA_TYPE    ZERO_WORD = 32'd0;
  localparam logic        TRUE      = 1'b1;
  localparam logic        FALSE     = 1'b0;

  typedef struct packed {
    ROB_ID_TYPE q;
    DATA_TYPE   v;
  } lookup_t;

  function automatic lookup_t lookup(
    input REG_POS_TYPE rs,
    input ROB_ID_TYPE  tag,
    input DATA_TYPE    val,
    input logic        cflag,
    input REG_POS_TYPE crd,
    input ROB_ID_TYPE  cq,
    input DATA_TYPE    cv
  );
    lookup_t r;
    r.q = tag;
    r.v = val;
    if (rs == ZERO_REG) begin
      r.q = ZERO_ROB;
      r.v = ZERO_WORD;
    end else if (cflag && crd == rs && tag == cq) begin
      r.q = ZERO_ROB;
      r.v = cv;
    end
    return r;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Dispatcher lookup/rename and ROB commit/flush signals.
// master = dispatcher + ROB side, slave = register file.
interface register_file_if;
  import register_file_pkg::*;

  REG_POS_TYPE rs1_from_dispatcher;
  REG_POS_TYPE rs2_from_dispatcher;
  ROB_ID_TYPE  Q1_to_dispatcher;
  DATA_TYPE    V1_to_dispatcher;
  ROB_ID_TYPE  Q2_to_dispatcher;
  DATA_TYPE    V2_to_dispatcher;
  logic        rename_signal_from_dispatcher;
  REG_POS_TYPE rd_from_dispatcher;
  ROB_ID_TYPE  rob_id_from_dispatcher;
  logic        commit_flag_from_rob;
  REG_POS_TYPE rd_from_rob;
  ROB_ID_TYPE  Q_from_rob;
  DATA_TYPE    V_from_rob;
  logic        misbranch_flag_from_rob;

  modport master (
    output rs1_from_dispatcher,
    output rs2_from_dispatcher,
    input  Q1_to_dispatcher,
    input  V1_to_dispatcher,
    input  Q2_to_dispatcher,
    input  V2_to_dispatcher,
    output rename_signal_from_dispatcher,
    output rd_from_dispatcher,
    output rob_id_from_dispatcher,
    output commit_flag_from_rob,
    output rd_from_rob,
    output Q_from_rob,
    output V_from_rob,
    output misbranch_flag_from_rob
  );

  modport slave (
    input  rs1_from_dispatcher,
    input  rs2_from_dispatcher,
    output Q1_to_dispatcher,
    output V1_to_dispatcher,
    output Q2_to_dispatcher,
    output V2_to_dispatcher,
    input  rename_signal_from_dispatcher,
    input  rd_from_dispatcher,
    input  rob_id_from_dispatcher,
    input  commit_flag_from_rob,
    input  rd_from_rob,
    input  Q_from_rob,
    input  V_from_rob,
    input  misbranch_flag_from_rob
  );

endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Combinational lookup with commit forwarding; clocked commit/rename/flush.
module register_file
  import register_file_pkg::*;
(
  input logic        clk,
  input logic        rst,
  input logic        rdy,
  register_file_if.slave bus
);

  DATA_TYPE   value_q [REG_NUM];
  DATA_TYPE   value_d [REG_NUM];
  ROB_ID_TYPE tag_q   [REG_NUM];
  ROB_ID_TYPE tag_d   [REG_NUM];

  lookup_t lk1;
  lookup_t lk2;

  // Operand lookup for both read ports, forwarding a matching commit.
  always_comb begin
    lk1 = lookup(bus.rs1_from_dispatcher,
                 tag_q[bus.rs1_from_dispatcher],
                 value_q[bus.rs1_from_dispatcher],
                 bus.commit_flag_from_rob,
                 bus.rd_from_rob,
                 bus.Q_from_rob,
                 bus.V_from_rob);
    lk2 = lookup(bus.rs2_from_dispatcher,
                 tag_q[bus.rs2_from_dispatcher],
                 value_q[bus.rs2_from_dispatcher],
                 bus.commit_flag_from_rob,
                 bus.rd_from_rob,
                 bus.Q_from_rob,
                 bus.V_from_rob);
  end

  assign bus.Q1_to_dispatcher = lk1.q;
  assign bus.V1_to_dispatcher = lk1.v;
  assign bus.Q2_to_dispatcher = lk2.q;
  assign bus.V2_to_dispatcher = lk2.v;

  // Next state: commit, then flush, then rename (rename wins on tag).
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (bus.commit_flag_from_rob && bus.rd_from_rob != ZERO_REG) begin
      value_d[bus.rd_from_rob] = bus.V_from_rob;
      if (tag_q[bus.rd_from_rob] == bus.Q_from_rob)
        tag_d[bus.rd_from_rob] = ZERO_ROB;
    end
    if (bus.misbranch_flag_from_rob) begin
      for (int i = 0; i < REG_NUM; i++)
        tag_d[i] = ZERO_ROB;
    end else if (bus.rename_signal_from_dispatcher &&
                 bus.rd_from_dispatcher != ZERO_REG) begin
      tag_d[bus.rd_from_dispatcher] = bus.rob_id_from_dispatcher;
    end
  end

  // State update; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '{default: ZERO_WORD};
      tag_q   <= '{default: ZERO_ROB};
    end else if (rdy) begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file.
// Expected lookups are queued at drive time and checked at sample time.
module tb_register_file;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  register_file_if bus();

  register_file dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [4:0]  q1;
    logic [31:0] v1;
    logic [4:0]  q2;
    logic [31:0] v2;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  task automatic cmp(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", t, obs, exp);
  endtask

  task automatic expect_lk(input string t,
                           input logic [4:0] q1, input logic [31:0] v1,
                           input logic [4:0] q2, input logic [31:0] v2);
    exp_t e;
    sb.push_back('{t, q1, v1, q2, v2});
    #1;
    e = sb.pop_front();
    cmp({e.tag, ".Q1"}, {27'd0, bus.Q1_to_dispatcher}, {27'd0, e.q1});
    cmp({e.tag, ".V1"}, bus.V1_to_dispatcher, e.v1);
    cmp({e.tag, ".Q2"}, {27'd0, bus.Q2_to_dispatcher}, {27'd0, e.q2});
    cmp({e.tag, ".V2"}, bus.V2_to_dispatcher, e.v2);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    bus.rename_signal_from_dispatcher = 1'b0;
    bus.rd_from_dispatcher = 5'd0;
    bus.rob_id_from_dispatcher = 5'd0;
    bus.commit_flag_from_rob = 1'b0;
    bus.rd_from_rob = 5'd0;
    bus.Q_from_rob = 5'd0;
    bus.V_from_rob = 32'd0;
    bus.misbranch_flag_from_rob = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] id);
    bus.rename_signal_from_dispatcher = 1'b1;
    bus.rd_from_dispatcher = rd;
    bus.rob_id_from_dispatcher = id;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] q,
                        input logic [31:0] v);
    bus.commit_flag_from_rob = 1'b1;
    bus.rd_from_rob = rd;
    bus.Q_from_rob = q;
    bus.V_from_rob = v;
  endtask

  task automatic rs(input logic [4:0] a, input logic [4:0] b);
    bus.rs1_from_dispatcher = a;
    bus.rs2_from_dispatcher = b;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    rs(5'd0, 5'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    rs(5'd5, 5'd0);
    expect_lk("reset", 5'd0, 32'd0, 5'd0, 32'd0);

    next_cycle();
    rename(5'd3, 5'd4);
    rs(5'd3, 5'd3);
    expect_lk("rename_same_cycle", 5'd0, 32'd0, 5'd0, 32'd0);
    next_cycle();
    expect_lk("rename_x3", 5'd4, 32'd0, 5'd4, 32'd0);

    next_cycle();
    commit(5'd3, 5'd4, 32'hDEADBEEF);
    expect_lk("fwd_x3", 5'd0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF);
    next_cycle();
    expect_lk("commit_x3", 5'd0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF);

    next_cycle();
    rename(5'd3, 5'd4);
    next_cycle();
    rename(5'd3, 5'd7);
    next_cycle();
    commit(5'd3, 5'd4, 32'h11);
    expect_lk("older_commit", 5'd7, 32'hDEADBEEF, 5'd7, 32'hDEADBEEF);
    next_cycle();
    expect_lk("young_tag_kept", 5'd7, 32'h11, 5'd7, 32'h11);

    next_cycle();
    commit(5'd8, 5'd2, 32'h55);
    rename(5'd8, 5'd9);
    rs(5'd8, 5'd3);
    expect_lk("commit_rename_same", 5'd0, 32'd0, 5'd7, 32'h11);
    next_cycle();
    expect_lk("rename_wins", 5'd9, 32'h55, 5'd7, 32'h11);

    next_cycle();
    rename(5'd1, 5'd10);
    next_cycle();
    rename(5'd2, 5'd11);
    next_cycle();
    rename(5'd31, 5'd12);
    next_cycle();
    rs(5'd1, 5'd2);
    expect_lk("tags_x1_x2", 5'd10, 32'd0, 5'd11, 32'd0);
    next_cycle();
    bus.misbranch_flag_from_rob = 1'b1;
    commit(5'd2, 5'd11, 32'h77);
    rename(5'd5, 5'd13);
    rs(5'd2, 5'd31);
    expect_lk("flush_cycle", 5'd0, 32'h77, 5'd12, 32'd0);
    next_cycle();
    rs(5'd1, 5'd31);
    expect_lk("flushed_1_31", 5'd0, 32'd0, 5'd0, 32'd0);
    next_cycle();
    rs(5'd2, 5'd5);
    expect_lk("flushed_2_5", 5'd0, 32'h77, 5'd0, 32'd0);
    next_cycle();
    rs(5'd8, 5'd3);
    expect_lk("flushed_8_3", 5'd0, 32'h55, 5'd0, 32'h11);

    next_cycle();
    rename(5'd0, 5'd3);
    commit(5'd0, 5'd0, 32'h1234);
    rs(5'd0, 5'd0);
    expect_lk("x0_same", 5'd0, 32'd0, 5'd0, 32'd0);
    next_cycle();
    expect_lk("x0_next", 5'd0, 32'd0, 5'd0, 32'd0);

    next_cycle();
    rdy = 1'b0;
    rename(5'd6, 5'd14);
    commit(5'd9, 5'd0, 32'h99);
    next_cycle();
    rdy = 1'b1;
    rs(5'd6, 5'd9);
    expect_lk("rdy_low_hold", 5'd0, 32'd0, 5'd0, 32'd0);

    next_cycle();
    rename(5'd3, 5'd15);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    rs(5'd3, 5'd2);
    expect_lk("reset_clears", 5'd0, 32'd0, 5'd0, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
